// File: rtl/cdc_2phase_rx_arb.sv
// Destination-domain receiver for NUM_CH two-phase (toggle) req/ack senders.
// Synchronises each req, picks a pending channel round-robin and queues {channel, payload} into a small FIFO.
module cdc_2phase_rx_arb #(
    parameter  int DATA_WID    = 8,
    parameter  int NUM_CH      = 2,
    parameter  int SYNC_STAGES = 2,
    parameter  int FIFO_DEPTH  = 4,
    localparam int CH_WID      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_WID     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          req_i,
    input  logic [NUM_CH*DATA_WID-1:0] data_i,
    output logic [NUM_CH-1:0]          ack_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DATA_WID-1:0]        data_o,
    output logic [CH_WID-1:0]          ch_o,
    output logic [CNT_WID-1:0]         count_o
);

    localparam int PTR_WID = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WID-1:0] DEPTH_C = CNT_WID'(FIFO_DEPTH);
    localparam logic [CH_WID-1:0]  LAST_CH = CH_WID'(NUM_CH - 1);

    logic [NUM_CH-1:0]   sync_p [SYNC_STAGES];
    logic [NUM_CH-1:0]   req_sync;
    logic [NUM_CH-1:0]   pending;
    logic [CH_WID-1:0]   last_grant;
    logic [NUM_CH-1:0]   grant_oh;
    logic [CH_WID-1:0]   grant_ch;
    logic [DATA_WID-1:0] grant_data;
    logic                grant_vld;
    int                  cand;
    logic                push_ok;
    logic                push;
    logic                pop;

    logic [DATA_WID-1:0] data_mem [FIFO_DEPTH];
    logic [CH_WID-1:0]   ch_mem   [FIFO_DEPTH];
    logic [PTR_WID-1:0]  wr_ptr;
    logic [PTR_WID-1:0]  rd_ptr;

    // Stage p0..pN: plain flop chain, nothing between stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_p[s] <= '0;
            end
        end else begin
            sync_p[0] <= req_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_p[s] <= sync_p[s-1];
            end
        end
    end

    assign req_sync = sync_p[SYNC_STAGES-1];
    assign pending  = req_sync ^ ack_o;

    // Round-robin search starting just after the previous winner
    always_comb begin
        grant_vld  = 1'b0;
        grant_ch   = last_grant;
        grant_oh   = '0;
        grant_data = '0;
        cand       = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = (int'(last_grant) + i) % NUM_CH;
            if (!grant_vld && pending[cand]) begin
                grant_vld      = 1'b1;
                grant_ch       = CH_WID'(cand);
                grant_oh[cand] = 1'b1;
                grant_data     = data_i[cand*DATA_WID +: DATA_WID];
            end
        end
    end

    assign valid_o = (count_o != '0);
    assign pop     = valid_o && ready_i;
    assign push_ok = (count_o < DEPTH_C) || pop;
    assign push    = push_ok && grant_vld;

    // Ack returns on the storing edge, so the sender is released before the consumer reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_o      <= '0;
            last_grant <= LAST_CH;
        end else if (push) begin
            ack_o      <= ack_o ^ grant_oh;
            last_grant <= grant_ch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WID'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WID'(1);
            end
            unique case ({push, pop})
                2'b10:   count_o <= count_o + CNT_WID'(1);
                2'b01:   count_o <= count_o - CNT_WID'(1);
                default: count_o <= count_o;
            endcase
        end
    end

    // Storage carries no reset; contents are qualified by count_o
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= grant_data;
            ch_mem[wr_ptr]   <= grant_ch;
        end
    end

    assign data_o = data_mem[rd_ptr];
    assign ch_o   = ch_mem[rd_ptr];

endmodule

// File: tb/tb_cdc_2phase_rx_arb.sv
// Bench for cdc_2phase_rx_arb: directed latency/arbitration/full/reset steps plus a randomized run
// against a queue-based model, on a 2-channel/depth-4 build and a 1-channel/depth-2 build.
module tb_cdc_2phase_rx_arb;

    typedef struct {
        int         ch;
        logic [7:0] d;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [1:0]  req_a;
    logic [15:0] data_a;
    logic [1:0]  ack_a;
    logic        valid_a;
    logic        ready_a;
    logic [7:0]  dout_a;
    logic        ch_a;
    logic [2:0]  cnt_a;

    logic        req_b;
    logic [7:0]  data_b;
    logic        ack_b;
    logic        valid_b;
    logic        ready_b;
    logic [7:0]  dout_b;
    logic        ch_b;
    logic [1:0]  cnt_b;

    cdc_2phase_rx_arb #(.DATA_WID(8), .NUM_CH(2), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_i(req_a), .data_i(data_a), .ack_o(ack_a),
        .valid_o(valid_a), .ready_i(ready_a), .data_o(dout_a), .ch_o(ch_a), .count_o(cnt_a)
    );

    cdc_2phase_rx_arb #(.DATA_WID(8), .NUM_CH(1), .SYNC_STAGES(2), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_i(req_b), .data_i(data_b), .ack_o(ack_b),
        .valid_o(valid_b), .ready_i(ready_b), .data_o(dout_b), .ch_o(ch_b), .count_o(cnt_b)
    );

    int   checks = 0;
    int   errors = 0;
    int   model_last;
    ent_t q[$];
    ent_t qb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input int ch, input logic [7:0] d);
        logic old_ack;
        old_ack = ack_a[ch];
        data_a[ch*8 +: 8] = d;
        req_a[ch] = ~req_a[ch];
        tick();
        tick();
        chk("single_pre_vld", valid_a, 0);
        chk("single_pre_ack", ack_a[ch], old_ack);
        tick();
        chk("single_vld", valid_a, 1);
        chk("single_dat", dout_a, d);
        chk("single_ch", ch_a, ch);
        chk("single_ack", ack_a[ch], req_a[ch]);
        chk("single_cnt", cnt_a, 1);
        tick();
        chk("single_drop_vld", valid_a, 0);
        chk("single_drop_cnt", cnt_a, 0);
        model_last = ch;
    endtask

    task automatic contention(input logic [7:0] d0, input logic [7:0] d1);
        int         first;
        logic [7:0] dd[2];
        dd[0] = d0;
        dd[1] = d1;
        first = (model_last + 1) % 2;
        data_a = {d1, d0};
        req_a = ~req_a;
        tick();
        tick();
        tick();
        chk("cont_first_vld", valid_a, 1);
        chk("cont_first_ch", ch_a, first);
        chk("cont_first_dat", dout_a, dd[first]);
        tick();
        chk("cont_second_vld", valid_a, 1);
        chk("cont_second_ch", ch_a, 1 - first);
        chk("cont_second_dat", dout_a, dd[1-first]);
        tick();
        chk("cont_empty", valid_a, 0);
        chk("cont_ack", ack_a, req_a);
        model_last = 1 - first;
    endtask

    task automatic send_a(input int ch, input logic [7:0] d);
        ent_t e;
        data_a[ch*8 +: 8] = d;
        req_a[ch] = ~req_a[ch];
        for (int i = 0; i < 30 && ack_a[ch] !== req_a[ch]; i++) tick();
        chk("send_ack", ack_a[ch], req_a[ch]);
        e.ch = ch;
        e.d = d;
        q.push_back(e);
        model_last = ch;
    endtask

    task automatic drain_a();
        ent_t e;
        ready_a = 1'b1;
        while (q.size() > 0) begin
            chk("drain_vld", valid_a, 1);
            chk("drain_ch", ch_a, q[0].ch);
            chk("drain_dat", dout_a, q[0].d);
            e = q.pop_front();
            tick();
        end
        chk("drain_empty", valid_a, 0);
    endtask

    task automatic send_b(input logic [7:0] d);
        ent_t e;
        data_b = d;
        req_b = ~req_b;
        for (int i = 0; i < 30 && ack_b !== req_b; i++) tick();
        chk("b_send_ack", ack_b, req_b);
        e.ch = 0;
        e.d = d;
        qb.push_back(e);
    endtask

    initial begin
        logic       old_ack;
        logic [1:0] prev_ack;
        logic       prev_pop;
        logic [7:0] outst[2];
        ent_t       e;
        int         nexp;
        int         sent;

        rst_n = 1'b0;
        req_a = '0; data_a = '0; ready_a = 1'b1;
        req_b = 1'b0; data_b = '0; ready_b = 1'b0;
        #12;
        chk("rst_ack", ack_a, 0);
        chk("rst_vld", valid_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk("rst_b_cnt", cnt_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        model_last = 1;

        // Arbitration order and single-transfer latency
        contention(8'h11, 8'h22);
        single(0, 8'hA5);
        contention(8'h33, 8'h44);
        single(1, 8'h5A);
        contention(8'h11, 8'h22);
        contention(8'h66, 8'h77);

        // Fill to full, hold a pending sender, then pop and push on one edge
        ready_a = 1'b0;
        q.delete();
        send_a(0, 8'h31);
        send_a(1, 8'h42);
        send_a(0, 8'h53);
        send_a(1, 8'h64);
        tick();
        chk("fill_cnt", cnt_a, 4);
        chk("fill_head", dout_a, 8'h31);
        old_ack = ack_a[0];
        data_a[7:0] = 8'h75;
        req_a[0] = ~req_a[0];
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("full_hold_ack", ack_a[0], old_ack);
            chk("full_hold_cnt", cnt_a, 4);
        end
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        chk("full_swap_cnt", cnt_a, 4);
        chk("full_swap_ack", ack_a[0], req_a[0]);
        e = q.pop_front();
        e.ch = 0;
        e.d = 8'h75;
        q.push_back(e);
        chk("full_swap_head", dout_a, q[0].d);
        model_last = 0;
        drain_a();

        // Back-to-back words on one channel
        ready_a = 1'b1;
        nexp = 0;
        data_a[7:0] = 8'h00;
        req_a[0] = ~req_a[0];
        sent = 1;
        for (int cyc = 0; cyc < 200 && nexp < 8; cyc++) begin
            tick();
            if (valid_a) begin
                chk("b2b_dat", dout_a, nexp);
                chk("b2b_ch", ch_a, 0);
                nexp++;
            end
            if (ack_a[0] === req_a[0] && sent < 8) begin
                data_a[7:0] = 8'(sent);
                req_a[0] = ~req_a[0];
                sent++;
            end
        end
        chk("b2b_words", nexp, 8);
        tick();
        chk("b2b_idle", valid_a, 0);

        // Randomized senders and consumer against the queue model
        q.delete();
        prev_ack = ack_a;
        prev_pop = 1'b0;
        outst[0] = '0;
        outst[1] = '0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (prev_pop && q.size() > 0) e = q.pop_front();
            chk("rnd_one_grant", ($countones(ack_a ^ prev_ack) <= 1), 1);
            for (int c = 0; c < 2; c++) begin
                if (ack_a[c] !== prev_ack[c]) begin
                    e.ch = c;
                    e.d = outst[c];
                    q.push_back(e);
                end
            end
            chk("rnd_cnt", cnt_a, q.size());
            chk("rnd_vld", valid_a, (q.size() != 0));
            if (q.size() > 0) begin
                chk("rnd_ch", ch_a, q[0].ch);
                chk("rnd_dat", dout_a, q[0].d);
            end
            ready_a = (cyc >= 640) || ($urandom_range(0, 2) != 0);
            prev_pop = valid_a && ready_a;
            for (int c = 0; c < 2; c++) begin
                if (cyc < 640 && ack_a[c] === req_a[c] && $urandom_range(0, 2) == 0) begin
                    outst[c] = 8'($urandom);
                    data_a[c*8 +: 8] = outst[c];
                    req_a[c] = ~req_a[c];
                end
            end
            prev_ack = ack_a;
            tick();
        end
        chk("rnd_drained", q.size(), 0);
        chk("rnd_ack_done", ack_a, req_a);

        // Asynchronous reset with entries queued
        ready_a = 1'b0;
        q.delete();
        send_a(0, 8'h81);
        send_a(1, 8'h92);
        tick();
        chk("prerst_cnt", cnt_a, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", valid_a, 0);
        chk("async_rst_cnt", cnt_a, 0);
        chk("async_rst_ack", ack_a, 0);
        req_a = '0;
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ready_a = 1'b1;
        model_last = 1;
        single(0, 8'hA5);

        // Single-channel, depth-2 build
        qb.delete();
        send_b(8'hC1);
        chk("b_ch0", ch_b, 0);
        send_b(8'hD2);
        tick();
        chk("b_full_cnt", cnt_b, 2);
        old_ack = ack_b;
        data_b = 8'hE3;
        req_b = ~req_b;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("b_hold_ack", ack_b, old_ack);
        end
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        chk("b_swap_cnt", cnt_b, 2);
        chk("b_swap_ack", ack_b, req_b);
        e = qb.pop_front();
        e.ch = 0;
        e.d = 8'hE3;
        qb.push_back(e);
        ready_b = 1'b1;
        while (qb.size() > 0) begin
            chk("b_drain_vld", valid_b, 1);
            chk("b_drain_ch", ch_b, 0);
            chk("b_drain_dat", dout_b, qb[0].d);
            e = qb.pop_front();
            tick();
        end
        chk("b_empty", valid_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_2phase_rx_arb.md
Name: cdc_2phase_rx_arb

Overview:
- Receive side of the 2-phase (toggle) req/ack CDC protocol, generalised to NUM_CH independent sender channels.
- Lives entirely in the destination clock domain. Synchronises each channel's req toggle through SYNC_STAGES flops and arbitrates pending channels round-robin.
- Captures the winner's data into a FIFO_DEPTH-entry FIFO and returns ack as soon as the data is stored, not when it is consumed, so senders are not throttled by the consumer.
- Output is a single valid/ready stream tagged with the source channel index.

Parameters:
- DATA_WID, 8: payload width per channel.
- NUM_CH, 2: number of sender channels, ≥1.
- SYNC_STAGES, 2: synchroniser flops per req line, ≥2.
- FIFO_DEPTH, 4: FIFO entries; power of two, ≥2.
- CH_WID (localparam): max(1, $clog2(NUM_CH)).
- CNT_WID (localparam): $clog2(FIFO_DEPTH+1).

Ports:
- clk  in  1  destination clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  NUM_CH  per-channel request toggle from the foreign domain (asynchronous).
- data_i  in  NUM_CH*DATA_WID  channel c occupies bits [c*DATA_WID +: DATA_WID]. Sender holds it stable while its req_i != ack_o.
- ack_o  out  NUM_CH  per-channel ack toggle, registered.
- valid_o  out  1  FIFO head valid.
- ready_i  in  1  consumer accepts the head.
- data_o  out  DATA_WID  head payload.
- ch_o  out  CH_WID  source channel of the head entry; tied 0 when NUM_CH=1.
- count_o  out  CNT_WID  FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Synchroniser flops, ack_o, FIFO pointers and count_o all clear to 0.
  - valid_o=0. data_o and ch_o read the slot-0 contents and are don't-care.
  - last_grant=NUM_CH-1, so channel 0 has first priority.
- Synchroniser: req_sync[c] is the last of SYNC_STAGES flops fed by req_i[c]. No logic sits between stages.
- pending[c] = req_sync[c] != ack_o[c] (combinational).
- Push enable: push_ok = (count_o < FIFO_DEPTH) || (valid_o && ready_i). A pop in the same cycle frees space for a push at full.
- Arbitration: on a cycle with push_ok and any pending bit set, grant exactly one channel g.
  - g is the first pending channel searching upward from (last_grant+1) mod NUM_CH, with wrap-around.
- On the granting edge:
  - Write {g, data_i slice g} at the write pointer.
  - Toggle ack_o[g] and set last_grant=g.
  - Advance the write pointer modulo FIFO_DEPTH.
- At most one grant per cycle. Because ack_o toggles on the granting edge, pending[g] clears on the next cycle and the same transfer is never granted twice.
- Pop: when valid_o && ready_i, advance the read pointer.
- count_o update: +1 on push only, -1 on pop only, unchanged on both or neither. valid_o = count_o != 0.
- data_o and ch_o are combinational reads of the head slot. They are stable while valid_o && !ready_i.
- Latency:
  - Sampling a req_i toggle at edge 1 updates req_sync at edge SYNC_STAGES.
  - The push happens at edge SYNC_STAGES+1, with valid_o high after it (FIFO empty, no contention).
  - The ack_o toggle is visible at the same edge as valid_o.
- Full with no pop: pending channels are held. Their ack is not toggled and no data is lost. They are granted once space appears.
- Sender protocol violations (toggling req again before seeing ack) are undefined.
- Reset mid-transfer drops FIFO contents and in-flight toggles. Senders must be reset in the same window.

Test Plan:
- Single transfer (SYNC_STAGES=2, NUM_CH=2, FIFO empty, ready_i=1): toggle req_i[0] with data 0xA5 -> ack_o[0] toggles and valid_o=1, data_o=0xA5, ch_o=0, exactly 3 edges after req sampled. valid_o drops the next cycle.
- Contention: req_i[0] and req_i[1] toggle in the same cycle with 0x11/0x22 -> FIFO order ch0/0x11 then ch1/0x22 on consecutive edges. Repeat both -> ch0 first again, since last_grant=1 and the search restarts at 0. Then with last_grant=0, toggle both -> ch1 first.
- Fill: ready_i=0, push 4 transfers -> count_o=4. A 5th toggle on ch0 -> ack_o[0] unchanged for 10 cycles. Assert ready_i for one cycle -> pop plus the 5th push on the same edge, count_o stays 4.
- Back-to-back on one channel: sender re-toggles immediately on each ack, 8 words 0..7, ready_i=1 -> data_o sequence 0..7, no duplicates, no gaps.
- Async reset mid-stream: assert rst_n=0 between clock edges with count_o=2 -> valid_o, count_o and ack_o read 0 immediately. After release, the first transfer behaves as in the single-transfer scenario.
- NUM_CH=1, FIFO_DEPTH=2 build: ch_o=0 always; the full/pop-simultaneous rule from the fill scenario holds at count_o=2.
